// File: rtl/full_adder_cell.sv
// full_adder_cell: purely combinational single-bit full adder.
//   a, b : operand bits
//   ci   : carry in from the next-lower bit (or the adder's cin)
//   s    : sum bit
//   co   : carry out to the next-higher bit
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder, {carry, sum} = a + b + cin.
// The result is available one clock after in_valid is sampled.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (clears sum, carry, out_valid)
//   in_valid  : qualifies a/b/cin on this edge
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry in
//   sum       : registered WIDTH-bit sum
//   carry     : registered carry out (MSB of the WIDTH+1-bit result)
//   out_valid : one-cycle pulse marking a freshly loaded result
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_comb;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum_comb[i]),
      .co (c[i+1])
    );
  end

  // Data registers only load on in_valid so they hold across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_comb;
        carry <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: checks a 1-bit and an 8-bit full_adder against an
// arithmetic reference model on every cycle, plus directed literal vectors.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c1 = 1'b0;
  logic [0:0] s1;
  logic       co1;
  logic       ov1;

  logic       iv8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       c8 = 1'b0;
  logic [7:0] s8;
  logic       co8;
  logic       ov8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .cin       (c1),
    .sum       (s1),
    .carry     (co1),
    .out_valid (ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
    .cin       (c8),
    .sum       (s8),
    .carry     (co8),
    .out_valid (ov8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result = integer sum of operands, held while idle.
  logic [1:0] m1_res;
  logic       m1_ov;
  logic [8:0] m8_res;
  logic       m8_ov;
  logic       model_known = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m1_res      <= 2'd0;
      m1_ov       <= 1'b0;
      m8_res      <= 9'd0;
      m8_ov       <= 1'b0;
      model_known <= 1'b1;
    end else begin
      m1_ov <= iv1;
      m8_ov <= iv8;
      if (iv1) m1_res <= 2'(a1) + 2'(b1) + 2'(c1);
      if (iv8) m8_res <= 9'(a8) + 9'(b8) + 9'(c8);
    end
  end

  always @(negedge clk) begin
    if (model_known) begin
      check("w1_sum",   64'(s1),  64'(m1_res[0]));
      check("w1_carry", 64'(co1), 64'(m1_res[1]));
      check("w1_valid", 64'(ov1), 64'(m1_ov));
      check("w8_sum",   64'(s8),  64'(m8_res[7:0]));
      check("w8_carry", 64'(co8), 64'(m8_res[8]));
      check("w8_valid", 64'(ov8), 64'(m8_ov));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exh_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [2:0] v;
    logic [8:0] last_res;

    // Reset with an operation presented: it must be discarded.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; iv1 = 1'b1;
    step;
    step;
    check("rst_sum",   64'(s1),  64'd0);
    check("rst_carry", 64'(co1), 64'd0);
    check("rst_valid", 64'(ov1), 64'd0);
    check("rst_sum8",  64'(s8),  64'd0);
    rst_n = 1'b1;
    step;
    check("rel_sum",   64'(s1),  64'd1);
    check("rel_carry", 64'(co1), 64'd1);
    check("rel_valid", 64'(ov1), 64'd1);

    // Exhaustive 1-bit truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      step;
      check("exh_res",   64'({co1, s1}), 64'(exh_tbl[i]));
      check("exh_valid", 64'(ov1),       64'd1);
    end

    // Hold: result stays while idle inputs wander.
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    step;
    check("hold_load_sum",   64'(s1),  64'd1);
    check("hold_load_carry", 64'(co1), 64'd0);
    iv1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      step;
      check("hold_sum",   64'(s1),  64'd1);
      check("hold_carry", 64'(co1), 64'd0);
      check("hold_valid", 64'(ov1), 64'd0);
    end

    // 8-bit boundary vectors.
    iv8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    step;
    check("rip_sum",   64'(s8),  64'h00);
    check("rip_carry", 64'(co8), 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    step;
    check("max_sum",   64'(s8),  64'hFF);
    check("max_carry", 64'(co8), 64'd1);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    step;
    check("zero_sum",   64'(s8),  64'h00);
    check("zero_carry", 64'(co8), 64'd0);
    a8 = 8'h5A; b8 = 8'hA5; c8 = 1'b0;
    step;
    check("mix_sum",   64'(s8),  64'hFF);
    check("mix_carry", 64'(co8), 64'd0);

    // Random back-to-back stream with a one-edge reset in the middle.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      last_res = 9'(a8) + 9'(b8) + 9'(c8);
      rst_n = (i != 500);
      step;
      if (i == 500) begin
        check("mid_rst_sum",   64'(s8),  64'd0);
        check("mid_rst_carry", 64'(co8), 64'd0);
        check("mid_rst_valid", 64'(ov8), 64'd0);
      end else begin
        check("rnd_res",   64'({co8, s8}), 64'(last_res));
        check("rnd_valid", 64'(ov8),       64'd1);
      end
    end
    rst_n = 1'b1;
    iv8 = 1'b0;
    step;
    check("end_valid", 64'(ov8), 64'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
